// File: rtl/instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_stream_encoder
// Purpose  : Field-level instruction encoder and instruction-memory writer.
//            Assembles addi / bne requests into RV32I words and writes them
//            to consecutive instruction-memory word addresses, starting at 0.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_kind   in   0 = addi, 1 = bne
//   req_rd     in   destination register (addi only)
//   req_rs1    in   source register 1
//   req_rs2    in   source register 2 (bne only)
//   req_imm    in   13-bit signed immediate / branch byte offset
//   prog_end   in   pulse: program complete, closes the stream
//   mem_we     out  single-cycle write strobe
//   mem_addr   out  word address of the write
//   mem_wdata  out  encoded instruction
//   count      out  number of words written
//   full       out  memory full, no further writes
//   done       out  program closed
//   err_range  out  sticky: addi immediate outside 12-bit signed range
//   err_align  out  sticky: bne offset odd
// Build option
//   ENCODER_RANGE_CHECK_EN : when defined, out-of-range addi immediates and
//   odd bne offsets are consumed but not written, and raise the sticky error
//   flags. When undefined, immediates are truncated and the flags read 0.
// ============================================================================
module instr_stream_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_kind,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [12:0]           req_imm,
  input  logic                  prog_end,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  done,
  output logic                  err_range,
  output logic                  err_align
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FULL   = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wp_q, wp_d;
  logic                    full_q, full_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    err_range_q, err_range_d;
  logic                    err_align_q, err_align_d;

  logic                    accept;
  logic                    range_bad;
  logic                    align_bad;
  logic                    reject;
  logic                    last_addr;
  logic [DATA_WIDTH-1:0]   enc_addi;
  logic [DATA_WIDTH-1:0]   enc_bne;

  assign req_ready = (state_q == ST_ACTIVE) && !full_q;
  assign accept    = req_valid && req_ready;

  // Immediate bit 0 of bne is never encoded; without checking it is dropped.
  assign enc_addi = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_OP_IMM};
  assign enc_bne  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                     req_imm[4:1], req_imm[11], OPC_BRANCH};

`ifdef ENCODER_RANGE_CHECK_EN
  // A 13-bit value fits 12-bit signed exactly when its top two bits agree.
  assign range_bad = !req_kind && (req_imm[12] != req_imm[11]);
  assign align_bad = req_kind && req_imm[0];
`else
  assign range_bad = 1'b0;
  assign align_bad = 1'b0;
`endif

  assign reject    = range_bad || align_bad;
  // The pointer stops at 2**ADDR_WIDTH, so the low bits all-ones marks the
  // final writable location.
  assign last_addr = &wp_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    full_d      = full_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_range_d = err_range_q;
    err_align_d = err_align_q;

    if (accept) begin
      // Rejected requests still complete the handshake; they only flag.
      err_range_d = err_range_q | range_bad;
      err_align_d = err_align_q | align_bad;
      if (!reject) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wp_q[ADDR_WIDTH-1:0];
        mem_wdata_d = req_kind ? enc_bne : enc_addi;
        wp_d        = wp_q + (ADDR_WIDTH+1)'(1);
        if (last_addr) begin
          full_d  = 1'b1;
          state_d = ST_FULL;
        end
      end
    end

    // prog_end wins over the FULL transition; the coincident write still lands.
    if (prog_end && (state_q != ST_DONE)) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACTIVE;
      wp_q        <= '0;
      full_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      full_q      <= full_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_range_q <= err_range_d;
      err_align_q <= err_align_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = wp_q;
  assign full      = full_q;
  assign done      = (state_q == ST_DONE);
  assign err_range = err_range_q;
  assign err_align = err_align_q;

endmodule
`default_nettype wire
